// File: rtl/tamagotchi_btn_frontend.sv
// Button front end for the pet FSM: sync + debounce on every raw pin, a priority
// arbiter that grants one care action at a time, and long-hold pulse detectors.

module tamagotchi_btn_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic pressed_i,
    output logic db_o
);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == DB_LAST) db_d  = ~db_q;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pressed_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    assign db_o = db_q;
endmodule

module tamagotchi_btn_frontend #(
    parameter bit ACTIVE_LOW   = 1'b1,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int HOLD_CYC     = 250_000_000,
    parameter int CNT_W        = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_salud,
    input  logic pin_energia,
    input  logic pin_hambre,
    input  logic pin_diversion,
    input  logic pin_reset,
    input  logic pin_test,
    output logic btn_salud,
    output logic btn_energia,
    output logic btn_hambre,
    output logic btn_diversion,
    output logic btn_reset,
    output logic btn_test,
    output logic hold_active
);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOCKOUT} arb_state_e;

    // Bit order doubles as arbitration priority: lowest index wins.
    logic [5:0] pressed, db;
    assign pressed = {pin_test, pin_reset, pin_diversion, pin_hambre, pin_energia, pin_salud}
                     ^ {6{ACTIVE_LOW}};

    for (genvar i = 0; i < 6; i++) begin : g_db
        tamagotchi_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_db (
            .clk       (clk),
            .rst       (rst),
            .pressed_i (pressed[i]),
            .db_o      (db[i])
        );
    end

    // Hold detectors: [0] reset, [1] test.
    logic [1:0][CNT_W-1:0] hcnt_q, hcnt_d;
    logic [1:0]            hpulse_q, hpulse_d;
    logic [1:0]            hdb;
    assign hdb = db[5:4];

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            hcnt_d[j] = '0;
            if (hdb[j]) hcnt_d[j] = (hcnt_q[j] == HOLD_MAX) ? HOLD_MAX : hcnt_q[j] + 1'b1;
            hpulse_d[j] = hdb[j] && (hcnt_q[j] == HOLD_LAST);
        end
        // Reset hold outranks test hold.
        hpulse_d[1] = hpulse_d[1] & ~hdb[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q   <= '0;
            hpulse_q <= '0;
        end else begin
            hcnt_q   <= hcnt_d;
            hpulse_q <= hpulse_d;
        end
    end

    // Action arbiter
    arb_state_e state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] act;
    assign act = db[3:0];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                grant_d = act & (~act + 4'd1);
                if (|act) state_d = GRANT;
            end
            GRANT: begin
                if (~|(grant_q & act)) begin
                    grant_d = '0;
                    state_d = (|act) ? LOCKOUT : IDLE;
                end
            end
            LOCKOUT: begin
                grant_d = '0;
                if (~|act) state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
        // Completed reset hold drops the grant in the same cycle the pulse appears.
        if (hpulse_d[0]) begin
            state_d = LOCKOUT;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign {btn_diversion, btn_hambre, btn_energia, btn_salud} = grant_q;
    assign btn_reset   = hpulse_q[0];
    assign btn_test    = hpulse_q[1];
    assign hold_active = (hdb[0] && hcnt_q[0] != HOLD_MAX) || (hdb[1] && hcnt_q[1] != HOLD_MAX);
endmodule
